// File: rtl/date_counter_pkg.sv
// date_counter_pkg: shared widths, reset date and month tables for the date counter.
package date_counter_pkg;
  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  localparam int YEAR_W = 7;
  localparam int WDAY_W = 3;
  localparam logic [DAY_W-1:0] RST_DAY = 5'd1;
  localparam logic [MON_W-1:0] RST_MONTH = 4'd1;
  localparam logic [YEAR_W-1:0] RST_YEAR = 7'd0;
  localparam logic [WDAY_W-1:0] RST_WDAY = 3'd6;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] DEC = 4'd12;
  localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;
  localparam logic [WDAY_W-1:0] MAX_WDAY = 3'd6;
  localparam logic [DAY_W-1:0] LEN_LONG = 5'd31;
  localparam logic [DAY_W-1:0] LEN_SHORT = 5'd30;
  localparam logic [DAY_W-1:0] LEN_FEB_LEAP = 5'd29;
  localparam logic [DAY_W-1:0] LEN_FEB = 5'd28;
  // One bit per month number; 0 and 13..15 stay clear so bad months get length 0.
  localparam logic [15:0] LONG_MONTHS = 16'h15AA;
  localparam logic [15:0] SHORT_MONTHS = 16'h0A50;
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return y[1:0] == 2'd0;
  endfunction
endpackage

// File: rtl/date_counter_month_len.sv
// month_len: combinational days-in-month lookup, 0 for an out-of-range month.
module month_len
  import date_counter_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic             leap,
  output logic [DAY_W-1:0] len
);
  assign len = LONG_MONTHS[month] ? LEN_LONG :
               SHORT_MONTHS[month] ? LEN_SHORT :
               month == FEB ? (leap ? LEN_FEB_LEAP : LEN_FEB) : '0;
endmodule

// File: rtl/date_counter.sv
// date_counter: calendar day/month/year/weekday counter for 2000..2099 with validated loads.
module date_counter
  import date_counter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              day_tick,
  input  logic              set_en,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [MON_W-1:0]  set_month,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [WDAY_W-1:0] set_wday,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic [YEAR_W-1:0] year,
  output logic [WDAY_W-1:0] wday,
  output logic              leap,
  output logic              year_wrap,
  output logic              set_err
);
  logic [DAY_W-1:0] cur_len, set_len;
  logic [YEAR_W-1:0] next_year;
  logic set_leap, set_ok, end_month, end_year;
  assign set_leap = is_leap(set_year);
  month_len u_cur_len (.month(month), .leap(leap), .len(cur_len));
  month_len u_set_len (.month(set_month), .leap(set_leap), .len(set_len));
  // A zero length from month_len also rejects months outside 1..12.
  assign set_ok = set_len != '0 && set_day != '0 && set_day <= set_len &&
                  set_year <= MAX_YEAR && set_wday <= MAX_WDAY;
  assign end_month = day == cur_len;
  assign end_year = end_month && month == DEC;
  assign next_year = year == MAX_YEAR ? '0 : year + 1'b1;
  always_ff @(posedge clk) begin
    year_wrap <= 1'b0;
    set_err <= 1'b0;
    if (rst) begin
      day <= RST_DAY;
      month <= RST_MONTH;
      year <= RST_YEAR;
      wday <= RST_WDAY;
      leap <= is_leap(RST_YEAR);
    end else if (set_en) begin
      if (set_ok) begin
        day <= set_day;
        month <= set_month;
        year <= set_year;
        wday <= set_wday;
        leap <= set_leap;
      end else set_err <= 1'b1;
    end else if (day_tick) begin
      wday <= wday == MAX_WDAY ? '0 : wday + 1'b1;
      day <= end_month ? RST_DAY : day + 1'b1;
      month <= end_year ? RST_MONTH : end_month ? month + 1'b1 : month;
      if (end_year) begin
        year <= next_year;
        leap <= is_leap(next_year);
        year_wrap <= year == MAX_YEAR;
      end
    end
  end
endmodule
